// File: rtl/ser_par_pkg.sv
// ---------------------------------------------------------------------------
// ser_par_pkg : shared types and constants for the comma aligner slice. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ser_par_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    function automatic int off_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comma_offset_finder.sv
// ---------------------------------------------------------------------------
// comma_offset_finder : combinational comma search over a 2-word window. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comma_offset_finder
    import ser_par_pkg::*;
#(
    parameter int                WORD_W = 8,
    parameter logic [WORD_W-1:0] COMMA  = WORD_W'(COMMA_DEFAULT),
    parameter int                OFF_W  = off_w(WORD_W)
) (
    input  logic [2*WORD_W-1:0] win_i,
    output logic                hit_o,
    output logic [OFF_W-1:0]    off_o,
    output logic [WORD_W-1:0]   hit_vec_o
);

    logic [WORD_W-1:0] w_hit;

    // Offset k starts k bits after the MSB (earliest bit) of the window.
    for (genvar k = 0; k < WORD_W; k++) begin : g_cand
        assign w_hit[k] = (win_i[2*WORD_W-1-k -: WORD_W] == COMMA);
    end

    always_comb begin
        off_o = '0;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                off_o = OFF_W'(k);
            end
        end
    end

    assign hit_o     = |w_hit;
    assign hit_vec_o = w_hit;

endmodule

`default_nettype wire

// File: rtl/comma_aligner_deser.sv
// ---------------------------------------------------------------------------
// comma_aligner_deser : comma hunt/verify/lock word aligner on clk_f. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comma_aligner_deser
    import ser_par_pkg::*;
#(
    parameter int                WORD_W   = 8,
    parameter logic [WORD_W-1:0] COMMA    = WORD_W'(COMMA_DEFAULT),
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3,
    parameter int                CNT_W    = 4
) (
    input  logic                      clk_f,
    input  logic                      reset,
    input  logic [WORD_W-1:0]         raw_in,
    input  logic                      raw_valid,
    input  logic                      realign,
    output logic [WORD_W-1:0]         par_out,
    output logic                      par_valid,
    output logic                      comma_det,
    output logic                      locked,
    output logic [$clog2(WORD_W)-1:0] align_offset
);

    localparam int OFF_W = off_w(WORD_W);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   prev_q, prev_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]    loss_cnt_q, loss_cnt_d;
    logic [WORD_W-1:0]   par_out_q, par_out_d;
    logic                par_valid_q, par_valid_d;
    logic                comma_det_q, comma_det_d;

    logic [2*WORD_W-1:0] w_win, w_shift;
    logic [WORD_W-1:0]   w_cand, w_hit_vec, w_self;
    logic [OFF_W-1:0]    w_hit_off;
    logic                w_hit, w_own, w_foreign;
    logic [CNT_W-1:0]    w_lock_inc, w_loss_inc;

    assign w_win  = {prev_q, raw_in};
    assign w_shift = w_win << offset_q;
    assign w_cand = w_shift[2*WORD_W-1 -: WORD_W];
    assign w_own  = (w_cand == COMMA);
    assign w_self = WORD_W'(1) << offset_q;
    assign w_foreign = |(w_hit_vec & ~w_self);

    assign w_lock_inc = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + 1'b1;
    assign w_loss_inc = (loss_cnt_q == '1) ? loss_cnt_q : loss_cnt_q + 1'b1;

    comma_offset_finder #(
        .WORD_W (WORD_W),
        .COMMA  (COMMA),
        .OFF_W  (OFF_W)
    ) u_finder (
        .win_i     (w_win),
        .hit_o     (w_hit),
        .off_o     (w_hit_off),
        .hit_vec_o (w_hit_vec)
    );

    always_ff @(posedge clk_f) begin
        if (!reset) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            offset_q    <= '0;
            lock_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            offset_q    <= offset_d;
            lock_cnt_q  <= lock_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            comma_det_q <= comma_det_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = raw_valid ? raw_in : prev_q;
        offset_d    = offset_q;
        lock_cnt_d  = lock_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        comma_det_d = comma_det_q;

        if (realign) begin
            state_d    = HUNT;
            lock_cnt_d = '0;
            loss_cnt_d = '0;
        end else if (raw_valid) begin
            case (state_q)
                HUNT: begin
                    if (w_hit) begin
                        offset_d   = w_hit_off;
                        lock_cnt_d = CNT_W'(1);
                        loss_cnt_d = '0;
                        state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_own) begin
                        lock_cnt_d = w_lock_inc;
                        if (w_lock_inc == CNT_W'(LOCK_CNT)) begin
                            state_d    = LOCKED;
                            loss_cnt_d = '0;
                        end
                    end else begin
                        state_d    = HUNT;
                        lock_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    par_out_d   = w_cand;
                    par_valid_d = 1'b1;
                    comma_det_d = w_own;
                    if (w_own) begin
                        loss_cnt_d = '0;
                    end else if (w_foreign) begin
                        loss_cnt_d = w_loss_inc;
                        // The loss-triggering word is still presented this cycle.
                        if (w_loss_inc == CNT_W'(LOSS_CNT)) begin
                            state_d    = HUNT;
                            lock_cnt_d = '0;
                            loss_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    lock_cnt_d = '0;
                    loss_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        par_out      = par_out_q;
        par_valid    = par_valid_q;
        comma_det    = comma_det_q;
        locked       = (state_q == LOCKED);
        align_offset = offset_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_comma_aligner_deser.sv
// ---------------------------------------------------------------------------
// tb_comma_aligner_deser : directed self-checking bench for the aligner. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_comma_aligner_deser;

    logic       clk_f = 1'b0;
    logic       reset;
    logic [7:0] raw_in;
    logic       raw_valid;
    logic       realign;
    logic [7:0] par_out;
    logic       par_valid;
    logic       comma_det;
    logic       locked;
    logic [2:0] align_offset;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_f = ~clk_f;

    comma_aligner_deser #(
        .WORD_W   (8),
        .COMMA    (8'hBC),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .CNT_W    (4)
    ) dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .raw_in       (raw_in),
        .raw_valid    (raw_valid),
        .realign      (realign),
        .par_out      (par_out),
        .par_valid    (par_valid),
        .comma_det    (comma_det),
        .locked       (locked),
        .align_offset (align_offset)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one word, let the DUT take it, sample 1 ns after the edge.
    task automatic step(input logic [7:0] d, input logic v, input logic ra);
        raw_in    = d;
        raw_valid = v;
        realign   = ra;
        @(posedge clk_f);
        #1;
    endtask

    task automatic lk(input string tag, input logic l, input logic pv, input logic [2:0] off);
        chk(tag, 32'({locked, par_valid, align_offset}), 32'({l, pv, off}));
    endtask

    task automatic dt(input string tag, input logic pv, input logic [7:0] po, input logic cd);
        chk(tag, 32'({par_valid, par_out, comma_det}), 32'({pv, po, cd}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        raw_in    = 8'h00;
        raw_valid = 1'b1;
        realign   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(8'($urandom), 1'b1, 1'b0);
            chk("reset_outs", 32'({par_out, par_valid, comma_det, locked, align_offset}), 32'd0);
        end
        reset = 1'b1;

        // Offset-3 training: 000 then BC repeated
        step(8'h17, 1'b1, 1'b0); lk("w1_nohit", 1'b0, 1'b0, 3'd0);
        step(8'h97, 1'b1, 1'b0); lk("w2_hit",   1'b0, 1'b0, 3'd3);
        step(8'h97, 1'b1, 1'b0);
        step(8'h97, 1'b1, 1'b0); lk("w4_verify", 1'b0, 1'b0, 3'd3);
        step(8'h97, 1'b1, 1'b0); lk("w5_lock",  1'b1, 1'b0, 3'd3);
        step(8'h8B, 1'b1, 1'b0); dt("first_bc", 1'b1, 8'hBC, 1'b1);
        step(8'h47, 1'b1, 1'b0); dt("pay_5a",   1'b1, 8'h5A, 1'b0);
        step(8'h97, 1'b1, 1'b0); dt("pay_3c",   1'b1, 8'h3C, 1'b0);
        step(8'h97, 1'b1, 1'b0); dt("bc_again", 1'b1, 8'hBC, 1'b1);

        // Loss: commas appear only at offset 5
        step(8'h05, 1'b1, 1'b0); dt("xfer_word", 1'b1, 8'hB8, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("loss1", 1'b1, 1'b1, 3'd3);
        dt("loss1_out", 1'b1, 8'h2F, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("loss2", 1'b1, 1'b1, 3'd3);
        step(8'hE5, 1'b1, 1'b0); lk("loss3_drop", 1'b0, 1'b1, 3'd3);
        dt("loss3_out", 1'b1, 8'h2F, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("hunt_hit5", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("relock5_wait", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("relock5", 1'b1, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); dt("relock5_bc", 1'b1, 8'hBC, 1'b1);

        // Forced realign while locked
        step(8'hE5, 1'b1, 1'b1); lk("realign", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("realign_wait", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("realign_relock", 1'b1, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); dt("realign_bc", 1'b1, 8'hBC, 1'b1);

        // Broken training: 2 commas then a non-comma at offset 5
        step(8'hE5, 1'b1, 1'b1);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0); lk("broken", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("broken_nohit", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0); lk("broken_cnt3", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("broken_relock", 1'b1, 1'b0, 3'd5);

        // raw_valid gaps during VERIFY
        step(8'hE5, 1'b1, 1'b1);
        step(8'hE5, 1'b1, 1'b0);
        step(8'hE5, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0); lk("gap_hold", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("gap_cnt3", 1'b0, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); lk("gap_lock", 1'b1, 1'b0, 3'd5);
        step(8'hE5, 1'b1, 1'b0); dt("gap_bc", 1'b1, 8'hBC, 1'b1);
        step(8'h00, 1'b0, 1'b0); dt("gap_pv_low", 1'b0, 8'hBC, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
